// File: rtl/weight_cache_pkg.sv
// Shared defaults and FSM state encoding for the weight-cache access controller.
package weight_cache_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } wc_state_t;

endpackage

// File: rtl/weight_cache_ctrl_rd_fifo.sv
// Two-entry synchronous FIFO that buffers SRAM read words ahead of the read stream.
module wc_rd_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/weight_cache_ctrl.sv
// Weight-cache SRAM access controller: load stream writes words, read stream replays them
// through a 2-entry buffer that hides the SRAM's one-cycle read latency.
module weight_cache_ctrl
    import weight_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH:0]   rd_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_cs_n,
    output logic                  sram_wr_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
        return (len > DEPTH_L) ? DEPTH_L : len;
    endfunction

    wc_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   cnt;       // words still to write (LOAD) or to issue (READ)
    logic [ADDR_WIDTH:0]   rd_left;   // words still to hand out on the read stream
    logic                  inflight;  // read issued last cycle, data on sram_rdata now
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_fire;
    logic                  issue;
    logic                  pop;
    logic                  last_wr;
    logic                  last_pop;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;

    wc_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (sram_rdata),
        .pop       (pop),
        .head_data (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};

    // Issue only while the buffer plus the word in flight cannot overflow two slots.
    assign issue    = (state == ST_READ) && (cnt != '0) &&
                      (occupancy < (3'd2 + {2'b00, pop}));
    assign wr_fire  = (state == ST_LOAD) && in_valid;
    assign last_wr  = wr_fire && (cnt == ONE_L);
    assign last_pop = (state == ST_READ) && pop && (rd_left == ONE_L);

    assign in_ready   = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE);
    assign out_last   = (state == ST_READ) && out_valid && (rd_left == ONE_L);
    assign sram_cs_n  = !(wr_fire || issue);
    assign sram_wr_n  = !wr_fire;
    assign sram_addr  = (wr_fire || issue) ? ptr : addr_q;
    assign sram_wdata = wr_fire ? in_data : wdata_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    if (clamp_len(load_len) != '0) state_nxt = ST_LOAD;
                end else if (rd_start && (clamp_len(rd_len) != '0)) begin
                    state_nxt = ST_READ;
                end
            end
            ST_LOAD: if (last_wr)  state_nxt = ST_IDLE;
            ST_READ: if (last_pop) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            rd_left  <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            done     <= last_wr || last_pop;
            inflight <= issue;
            addr_q   <= sram_addr;
            wdata_q  <= sram_wdata;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        ptr <= load_base;
                        cnt <= clamp_len(load_len);
                    end else if (rd_start) begin
                        ptr     <= rd_base;
                        cnt     <= clamp_len(rd_len);
                        rd_left <= clamp_len(rd_len);
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                        cnt <= cnt - ONE_L;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                        cnt <= cnt - ONE_L;
                    end
                    if (pop) begin
                        rd_left <= rd_left - ONE_L;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_cache_ctrl.sv
// Directed-plus-random bench for weight_cache_ctrl against an array/queue reference of the cache.
module tb_weight_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, rd_start;
    logic [7:0]  load_base, rd_base;
    logic [8:0]  load_len, rd_len;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
    logic [31:0] in_data, out_data;
    logic        sram_cs_n, sram_wr_n;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    int vectors = 0;
    int miscompares = 0;

    weight_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done),
        .sram_cs_n(sram_cs_n), .sram_wr_n(sram_wr_n), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Registered-address SRAM macro.
    always @(posedge clk) begin
        if (!sram_cs_n) begin
            if (!sram_wr_n) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_last"}, 64'(out_last), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_cs_n"}, 64'(sram_cs_n), 64'(1));
        chk({tag, "_wr_n"}, 64'(sram_wr_n), 64'(1));
        chk({tag, "_addr"}, 64'(sram_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(sram_wdata), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    endtask

    task automatic do_load(input int base, input int len, input bit rand_valid,
                           input bit with_rd, input bit fixed);
        int n, acc, cyc;
        logic [31:0] d;
        n = (len > 256) ? 256 : len;
        @(negedge clk);
        load_start = 1'b1; load_base = 8'(base); load_len = 9'(len);
        rd_start = with_rd; rd_base = 8'd0; rd_len = 9'd4;
        #2 chk("load_start_busy", 64'(busy), 64'(0));
        @(negedge clk);
        load_start = 1'b0; rd_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < n && cyc < n * 8 + 50) begin
            cyc++;
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            d = fixed ? 32'(32'h11 * (acc + 1)) : $urandom;
            in_data = d;
            if (cyc == 2) rd_start = 1'b1;
            #2;
            chk("load_in_ready", 64'(in_ready), 64'(1));
            chk("load_busy", 64'(busy), 64'(1));
            chk("load_cs_n", 64'(sram_cs_n), 64'(!in_valid));
            chk("load_no_out", 64'(out_valid), 64'(0));
            if (in_valid) begin
                chk("load_wr_n", 64'(sram_wr_n), 64'(0));
                chk("load_addr", 64'(sram_addr), 64'((base + acc) % 256));
                chk("load_wdata", 64'(sram_wdata), 64'(d));
                ref_mem[(base + acc) % 256] = d;
                acc++;
            end
            @(negedge clk);
            rd_start = 1'b0;
        end
        in_valid = 1'b0;
        if (acc < n) chk("load_timeout", 64'(acc), 64'(n));
        #2;
        chk("load_done", 64'(done), 64'(1));
        chk("load_end_busy", 64'(busy), 64'(0));
        chk("load_end_ready", 64'(in_ready), 64'(0));
        chk("load_end_cs_n", 64'(sram_cs_n), 64'(1));
        @(negedge clk);
        #2;
        chk("load_done_pulse", 64'(done), 64'(0));
        chk("load_after_busy", 64'(busy), 64'(0));
    endtask

    // mode 0: out_ready held high; 1: pattern 1,0,0,1; 2: random.
    task automatic do_read(input int base, input int len, input int mode, input int abort_after);
        int n, issued, popped, cyc, first_v, last_cyc;
        bit stalled;
        n = (len > 256) ? 256 : len;
        @(negedge clk);
        rd_start = 1'b1; rd_base = 8'(base); rd_len = 9'(len);
        #2 chk("rd_start_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rd_start = 1'b0;
        issued = 0; popped = 0; cyc = 0; first_v = 0; last_cyc = 0; stalled = 0;
        while (popped < n && cyc < n * 8 + 50) begin
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #2;
            chk("rd_busy", 64'(busy), 64'(1));
            if (cyc == 1) chk("rd_first_issue", 64'(sram_cs_n), 64'(0));
            if (cyc <= 2) chk("rd_latency", 64'(out_valid), 64'(0));
            if (!sram_cs_n) begin
                chk("rd_wr_n", 64'(sram_wr_n), 64'(1));
                chk("rd_addr", 64'(sram_addr), 64'((base + issued) % 256));
                issued++;
            end
            if (stalled) chk("rd_hold_valid", 64'(out_valid), 64'(1));
            if (out_valid) begin
                if (first_v == 0) first_v = cyc;
                chk("rd_data", 64'(out_data), 64'(ref_mem[(base + popped) % 256]));
                chk("rd_last", 64'(out_last), 64'(popped == n - 1));
                stalled = !out_ready;
                if (out_ready) begin
                    popped++;
                    last_cyc = cyc;
                end
            end else begin
                chk("rd_last_idle", 64'(out_last), 64'(0));
                stalled = 0;
            end
            chk("rd_outstanding", 64'(issued - popped <= 2), 64'(1));
            chk("rd_overissue", 64'(issued <= n), 64'(1));
            if (abort_after != 0 && popped == abort_after) return;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (popped < n) chk("rd_timeout", 64'(popped), 64'(n));
        if (mode == 0) begin
            chk("rd_first_valid_cycle", 64'(first_v), 64'(3));
            chk("rd_last_word_cycle", 64'(last_cyc), 64'(n + 2));
        end
        #2;
        chk("rd_done", 64'(done), 64'(1));
        chk("rd_end_busy", 64'(busy), 64'(0));
        chk("rd_end_valid", 64'(out_valid), 64'(0));
        chk("rd_end_cs_n", 64'(sram_cs_n), 64'(1));
        @(negedge clk);
        #2 chk("rd_done_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0; load_base = '0; load_len = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_load(0, 4, 0, 0, 1);
        do_read(0, 4, 0, 0);
        do_read(0, 4, 1, 0);

        do_load(254, 4, 0, 0, 0);
        do_read(254, 4, 0, 0);

        // Simultaneous starts: load wins and no read words appear.
        do_load(10, 3, 0, 1, 0);

        @(negedge clk);
        load_start = 1'b1; load_len = 9'd0;
        @(negedge clk);
        load_start = 1'b0;
        #2;
        chk("len0_load_busy", 64'(busy), 64'(0));
        chk("len0_load_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rd_start = 1'b1; rd_len = 9'd0;
        @(negedge clk);
        rd_start = 1'b0;
        #2;
        chk("len0_rd_busy", 64'(busy), 64'(0));
        chk("len0_rd_cs_n", 64'(sram_cs_n), 64'(1));
        @(negedge clk);
        #2;
        chk("len0_done", 64'(done), 64'(0));
        chk("len0_valid", 64'(out_valid), 64'(0));

        // Oversized lengths clamp to the full cache.
        do_load(int'($urandom_range(0, 255)), 300, 1, 0, 0);
        do_read(int'($urandom_range(0, 255)), 300, 2, 0);

        for (int j = 0; j < 4; j++) begin
            do_load(int'($urandom_range(0, 255)), int'($urandom_range(1, 20)), 1, 0, 0);
            do_read(int'($urandom_range(0, 255)), int'($urandom_range(1, 20)),
                    int'($urandom_range(0, 2)), 0);
        end

        // Asynchronous reset in the middle of a read job.
        do_read(0, 8, 0, 2);
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2 chk("midreset_no_done", 64'(done), 64'(0));
        do_read(0, 4, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
